// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader and its run timer.
package boot_pkg;

  // Width defaults matching the processor top level.
  localparam int DEF_IW = 9;   // instruction / stream word width
  localparam int DEF_IA = 12;  // instruction memory address width (PC width)
  localparam int DEF_DW = 8;   // data memory word width
  localparam int DEF_DA = 8;   // data memory address width

  // Largest legal header values.
  localparam int MAX_NI = 511;
  localparam int MAX_ND = 256;

  // Loader FSM states. DONE, TOUT and ERR are absorbing.
  typedef enum logic [2:0] {
    HDR0   = 3'd0,
    HDR1   = 3'd1,
    LOAD_I = 3'd2,
    LOAD_D = 3'd3,
    RUN    = 3'd4,
    DONE   = 3'd5,
    TOUT   = 3'd6,
    ERR    = 3'd7
  } boot_state_t;

endpackage

// File: rtl/boot_loader_if.sv
// Stream input and memory write bus of the boot loader.
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready
// are both 1. The source holds in_data stable while in_valid is high and not
// yet accepted; in_ready is a function of the loader state only, so it never
// depends combinationally on in_valid.
interface boot_loader_if #(
  parameter int IW = boot_pkg::DEF_IW,
  parameter int IA = boot_pkg::DEF_IA,
  parameter int DW = boot_pkg::DEF_DW,
  parameter int DA = boot_pkg::DEF_DA
) ();

  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_ready;

  logic          imem_we;
  logic [IA-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;

  logic          dmem_we;
  logic [DA-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;

  // Upstream stream source / memory side (bench or system glue).
  modport master (
    output in_valid, in_data,
    input  in_ready,
    input  imem_we, imem_addr, imem_wdata,
    input  dmem_we, dmem_addr, dmem_wdata
  );

  // The loader itself.
  modport slave (
    input  in_valid, in_data,
    output in_ready,
    output imem_we, imem_addr, imem_wdata,
    output dmem_we, dmem_addr, dmem_wdata
  );

endinterface

// File: rtl/boot_loader_run_timer.sv
// Execution cycle counter for the RUN phase.
// Counts once per running cycle starting from 0, freezes on the cycle the
// core reports done, and flags when the count sits at MAX_CYCLES-1 so the
// loader can declare a timeout on that same cycle.
module run_timer #(
  parameter int CW         = 16,
  parameter int MAX_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          reset,      // synchronous, active low
  input  logic          clear,      // return the count to 0
  input  logic          run,        // loader is in RUN this cycle
  input  logic          core_done,
  output logic [CW-1:0] count,
  output logic          at_limit
);

  localparam logic [CW-1:0] LIMIT = CW'(MAX_CYCLES - 1);

  // Last cycle of the timeout window.
  always_comb begin
    at_limit = (count == LIMIT);
  end

  // Count RUN cycles; hold the value on done or at the limit so it reports
  // the count seen on the exit cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && !core_done && !at_limit) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Boot loader: receives a header plus program/data image over a valid/ready
// stream, writes it into instruction and data memory, then releases the core
// and times its execution until done or timeout.
//
// Stream layout: NI, ND, NI instruction words, ND data words (low DW bits).
module boot_loader import boot_pkg::*; #(
  parameter int IW         = DEF_IW,
  parameter int IA         = DEF_IA,
  parameter int DW         = DEF_DW,
  parameter int DA         = DEF_DA,
  parameter int MAX_CYCLES = 4096,
  parameter int CW         = 16
) (
  input  logic          clk,
  input  logic          reset,        // synchronous, active low
  boot_loader_if.slave  bus,
  output logic          core_hold,
  input  logic          core_done,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic          hdr_err,
  output logic [CW-1:0] cycle_count,
  output boot_state_t   state_dbg
);

  // Data counter needs one extra bit so a 256-byte image can be counted
  // without the address itself ever wrapping.
  localparam int NW = DA + 1;

  boot_state_t   state, state_nxt;

  logic [IW-1:0] ni;
  logic [NW-1:0] nd;
  logic [IA-1:0] i_cnt;
  logic [NW-1:0] d_cnt;

  // Set for the one cycle after the final image word is accepted. The last
  // write strobe is on the bus during that cycle and lands on the edge that
  // enters RUN, so the core never runs against a partial image.
  logic          drain;

  logic          in_ready;
  logic          hs;
  logic          i_last;
  logic          d_last;
  logic          hdr0_bad;
  logic          hdr1_bad;
  logic          timer_at_limit;

  logic          imem_we_q;
  logic [IA-1:0] imem_addr_q;
  logic [IW-1:0] imem_wdata_q;
  logic          dmem_we_q;
  logic [DA-1:0] dmem_addr_q;
  logic [DW-1:0] dmem_wdata_q;

  // Stream acceptance and load-progress decodes.
  always_comb begin
    in_ready = ((state == HDR0) || (state == HDR1) ||
                (state == LOAD_I) || (state == LOAD_D)) && !drain;
    hs       = bus.in_valid && in_ready;
    i_last   = (i_cnt == IA'(ni - IW'(1)));
    d_last   = (d_cnt == (nd - NW'(1)));
    hdr0_bad = (bus.in_data == '0);
    hdr1_bad = (bus.in_data > IW'(MAX_ND));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= HDR0;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      HDR0: begin
        if (hs) state_nxt = hdr0_bad ? ERR : HDR1;
      end
      HDR1: begin
        if (hs) state_nxt = hdr1_bad ? ERR : LOAD_I;
      end
      LOAD_I: begin
        if (drain) begin
          state_nxt = RUN;
        end else if (hs && i_last && (nd != '0)) begin
          state_nxt = LOAD_D;
        end
      end
      LOAD_D: begin
        if (drain) state_nxt = RUN;
      end
      RUN: begin
        // Done takes priority over a timeout on the same cycle.
        if (core_done) begin
          state_nxt = DONE;
        end else if (timer_at_limit) begin
          state_nxt = TOUT;
        end
      end
      default: state_nxt = state;
    endcase
  end

  // Header latches, load counters and the drain marker.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ni    <= '0;
      nd    <= '0;
      i_cnt <= '0;
      d_cnt <= '0;
      drain <= 1'b0;
    end else begin
      drain <= hs && (((state == LOAD_I) && i_last && (nd == '0)) ||
                      ((state == LOAD_D) && d_last));
      if (hs) begin
        case (state)
          HDR0: begin
            ni    <= bus.in_data;
            i_cnt <= '0;
            d_cnt <= '0;
          end
          HDR1:    nd    <= NW'(bus.in_data);
          LOAD_I:  i_cnt <= i_cnt + IA'(1);
          LOAD_D:  d_cnt <= d_cnt + NW'(1);
          default: ;
        endcase
      end
    end
  end

  // Registered memory writes: strobe for one cycle after each accepted
  // image word; address and data hold between strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      imem_we_q <= hs && (state == LOAD_I);
      dmem_we_q <= hs && (state == LOAD_D);
      if (hs && (state == LOAD_I)) begin
        imem_addr_q  <= i_cnt;
        imem_wdata_q <= bus.in_data;
      end
      if (hs && (state == LOAD_D)) begin
        dmem_addr_q  <= d_cnt[DA-1:0];
        dmem_wdata_q <= bus.in_data[DW-1:0];
      end
    end
  end

  run_timer #(
    .CW         (CW),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_run_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == HDR0),
    .run       (state == RUN),
    .core_done (core_done),
    .count     (cycle_count),
    .at_limit  (timer_at_limit)
  );

  // Status outputs decoded from the state. The core stays released in DONE
  // so its memories remain observable.
  always_comb begin
    core_hold = !((state == RUN) || (state == DONE));
    busy      = (state == HDR1) || (state == LOAD_I) ||
                (state == LOAD_D) || (state == RUN);
    finished  = (state == DONE);
    timeout   = (state == TOUT);
    hdr_err   = (state == ERR);
    state_dbg = state;
  end

  // Drive the bus.
  always_comb begin
    bus.in_ready   = in_ready;
    bus.imem_we    = imem_we_q;
    bus.imem_addr  = imem_addr_q;
    bus.imem_wdata = imem_wdata_q;
    bus.dmem_we    = dmem_we_q;
    bus.dmem_addr  = dmem_addr_q;
    bus.dmem_wdata = dmem_wdata_q;
  end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: directed streams, scoreboard of expected memory
// writes checked by an independent monitor, plus status/timing checks.
module tb_boot_loader;
  import boot_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  boot_loader_if bus ();

  logic        core_hold;
  logic        core_done;
  logic        busy;
  logic        finished;
  logic        timeout;
  logic        hdr_err;
  logic [15:0] cycle_count;
  boot_state_t state_dbg;

  boot_loader #(
    .MAX_CYCLES (16),
    .CW         (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .core_hold   (core_hold),
    .core_done   (core_done),
    .busy        (busy),
    .finished    (finished),
    .timeout     (timeout),
    .hdr_err     (hdr_err),
    .cycle_count (cycle_count),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  // Entry: {is_dmem, addr[11:0], data[8:0]}
  logic [21:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int last_we_cyc = 0;
  int hold_fall_cyc = 0;
  logic hold_prev = 1'b1;

  logic [8:0] iwords[$];
  logic [8:0] dbytes[$];

  function automatic logic [21:0] i_ent(input int addr, input logic [8:0] data);
    logic [11:0] a;
    a = 12'(addr);
    return {1'b0, a, data};
  endfunction

  function automatic logic [21:0] d_ent(input int addr, input logic [8:0] data);
    logic [7:0] a;
    a = 8'(addr);
    return {1'b1, 4'b0, a, 1'b0, data[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    logic [21:0] got;
    logic [21:0] exp;
    cyc++;
    if (hold_prev && !core_hold) hold_fall_cyc = cyc;
    hold_prev = core_hold;
    if (bus.imem_we && bus.dmem_we) begin
      checks++;
      errors++;
      $display("FAIL both_strobes imem_we=%0b dmem_we=%0b expected one at most", bus.imem_we, bus.dmem_we);
    end else if (bus.imem_we || bus.dmem_we) begin
      last_we_cyc = cyc;
      if (bus.imem_we) got = {1'b0, bus.imem_addr, bus.imem_wdata};
      else             got = {1'b1, 4'b0, bus.dmem_addr, 1'b0, bus.dmem_wdata};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got %0h expected no write", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL mem_write got %0h expected %0h", got, exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [8:0] w, input bit rnd, input bit has_exp, input logic [21:0] exp);
    int n;
    bit got_hs;
    if (rnd) begin
      int idle;
      idle = $urandom_range(0, 2);
      repeat (idle) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    n = 0;
    got_hs = 1'b0;
    while (!got_hs && n < 20) begin
      #1;
      if (bus.in_ready) begin
        got_hs = 1'b1;
        if (has_exp) exp_q.push_back(exp);
      end
      @(negedge clk);
      n++;
    end
    if (!got_hs) begin
      checks++;
      errors++;
      $display("FAIL send_accept got in_ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic load_stream(input bit rnd);
    send(9'(iwords.size()), rnd, 1'b0, '0);
    send(9'(dbytes.size()), rnd, 1'b0, '0);
    foreach (iwords[k]) send(iwords[k], rnd, 1'b1, i_ent(k, iwords[k]));
    foreach (dbytes[j]) send(dbytes[j], rnd, 1'b1, d_ent(j, dbytes[j]));
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_hold_low(input int bound);
    int n;
    n = 0;
    while (core_hold && n < bound) begin
      @(negedge clk);
      n++;
    end
    #2;
    check("hold_released", core_hold, 0);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    core_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    check("rst_hold", core_hold, 1);
    check("rst_busy", busy, 0);
    check("rst_flags", {finished, timeout, hdr_err}, 0);
    check("rst_count", cycle_count, 0);
    check("rst_strobes", {bus.imem_we, bus.dmem_we}, 0);
    check("rst_ready", bus.in_ready, 1);
    check("rst_state", state_dbg, HDR0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b0;
    core_done = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;

    // Basic image, valid every cycle, core done in its 10th cycle.
    do_reset();
    iwords = '{9'h1A5, 9'h003, 9'h1FF};
    dbytes = '{9'h012, 9'h034};
    load_stream(1'b0);
    check("busy_loading", busy, 1);
    wait_hold_low(10);
    check("hold_after_last_write", hold_fall_cyc, last_we_cyc + 1);
    check("writes_done_t1", exp_q.size(), 0);
    check("run_start_count", cycle_count, 0);
    check("ready_in_run", bus.in_ready, 0);
    repeat (9) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    check("done_finished", finished, 1);
    check("done_count", cycle_count, 9);
    check("done_hold", core_hold, 0);
    check("done_busy", busy, 0);
    check("done_no_timeout", timeout, 0);
    repeat (5) @(negedge clk);
    check("done_sticky", {finished, cycle_count}, {1'b1, 16'd9});

    // Same image with gaps in in_valid; bit 8 of data words ignored.
    do_reset();
    dbytes = '{9'h112, 9'h134};
    load_stream(1'b1);
    wait_hold_low(10);
    check("writes_done_t2", exp_q.size(), 0);
    check("ready_in_run_rnd", bus.in_ready, 0);

    // NI = 0: header error, nothing written, done ignored.
    do_reset();
    send(9'h000, 1'b0, 1'b0, '0);
    bus.in_valid = 1'b1;
    bus.in_data = 9'h005;
    core_done = 1'b1;
    repeat (4) @(negedge clk);
    core_done = 1'b0;
    bus.in_valid = 1'b0;
    check("ni0_hdr_err", hdr_err, 1);
    check("ni0_hold", core_hold, 1);
    check("ni0_ready", bus.in_ready, 0);
    check("ni0_not_finished", finished, 0);
    check("ni0_busy", busy, 0);

    // ND = 257: header error.
    do_reset();
    send(9'h001, 1'b0, 1'b0, '0);
    send(9'h101, 1'b0, 1'b0, '0);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("nd257_hdr_err", hdr_err, 1);
    check("nd257_hold", core_hold, 1);
    check("nd257_state", state_dbg, ERR);

    // ND = 256, then let the core time out (MAX_CYCLES = 16).
    do_reset();
    iwords = '{9'h0AA};
    dbytes.delete();
    for (int j = 0; j < 256; j++) dbytes.push_back(9'(j) ^ 9'h15A);
    load_stream(1'b0);
    wait_hold_low(10);
    check("nd256_all_written", exp_q.size(), 0);
    check("nd256_hold_after_write", hold_fall_cyc, last_we_cyc + 1);
    n = 1;
    while (!timeout && n < 40) begin
      @(negedge clk);
      if (!timeout) n++;
    end
    check("tout_run_cycles", n, 16);
    check("tout_flag", timeout, 1);
    check("tout_hold", core_hold, 1);
    check("tout_count", cycle_count, 15);
    check("tout_not_finished", finished, 0);
    check("tout_busy", busy, 0);

    // Done on the final allowed cycle wins over the timeout.
    do_reset();
    iwords = '{9'h0AB};
    dbytes.delete();
    load_stream(1'b0);
    wait_hold_low(10);
    repeat (15) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    check("tie_finished", finished, 1);
    check("tie_no_timeout", timeout, 0);
    check("tie_count", cycle_count, 15);

    // Reset in the middle of LOAD_I, then reload from address 0.
    do_reset();
    send(9'h005, 1'b0, 1'b0, '0);
    send(9'h000, 1'b0, 1'b0, '0);
    send(9'h111, 1'b0, 1'b1, i_ent(0, 9'h111));
    send(9'h122, 1'b0, 1'b1, i_ent(1, 9'h122));
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("midrst_state", state_dbg, HDR0);
    check("midrst_hold", core_hold, 1);
    check("midrst_busy", busy, 0);
    check("midrst_strobe", bus.imem_we, 0);
    reset = 1'b1;
    iwords = '{9'h0CD};
    load_stream(1'b0);
    wait_hold_low(10);
    check("midrst_reload_done", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog got no end of test expected finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
